// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t  : FSM state encoding (IDLE, DATA, FETCH, DONE)
//   OP_READ/OP_WRITE : captured data-access operation
//   BUBBLE_INSTR : instruction word loaded on reset or on an aborted fetch
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundles for the memory arbiter.
//   arb_cpu_if : CPU side (fetch + load/store requests, results, stall, bus_err)
//                master = CPU, slave = arbiter
//   arb_mem_if : shared memory port (req/we/addr/wdata out, ready/rdata back)
//                master = arbiter, slave = memory
interface arb_cpu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_read;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] instr_out;
  logic              data_read;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              stall;
  logic              bus_err;

  modport master (
    output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
    input  instr_out, data_out, stall, bus_err
  );

  modport slave (
    input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
    output instr_out, data_out, stall, bus_err
  );
endinterface

interface arb_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// arb_wait_timer: wait-cycle watchdog for the memory port.
//   clk, rst  : clock and synchronous active-high reset
//   clear_i   : zero the counter (has priority over enable_i)
//   enable_i  : count one wait cycle
//   timeout_o : high in the wait cycle that would bring the count to WAIT_MAX
module arb_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the WAIT_MAX-th consecutive wait cycle, so mem_req is held
  // without an answer for exactly WAIT_MAX cycles before the abort.
  assign timeout_o = enable_i && (cnt_q == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises a CPU step's data access and instruction fetch onto
// one memory port, holding the pipeline via stall until both complete.
//   clk, rst : clock and synchronous active-high reset
//   cpu      : arb_cpu_if.slave  (requests in; instr_out/data_out/stall/bus_err out)
//   mem      : arb_mem_if.master (mem_req/we/addr/wdata out; mem_ready/rdata in)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  arb_cpu_if.slave   cpu,
  arb_mem_if.master  mem
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic              op_q;
  logic              fetch_pend_q;
  logic [ADDR_W-1:0] daddr_q, faddr_q;
  logic [DATA_W-1:0] wdata_q, instr_q, dout_q;
  logic              bus_err_q;

  logic data_req, in_access, access_done, timeout;

  assign data_req    = cpu.data_read | cpu.data_write;
  assign in_access   = (state_q == S_DATA) || (state_q == S_FETCH);
  // An aborted access advances the FSM exactly like a completed one.
  assign access_done = in_access && (mem.mem_ready || timeout);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_req)            state_d = S_DATA;
        else if (cpu.instr_read) state_d = S_FETCH;
      end
      S_DATA:  if (access_done) state_d = fetch_pend_q ? S_FETCH : S_DONE;
      S_FETCH: if (access_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  arb_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_d != state_q),
    .enable_i  (in_access && !mem.mem_ready),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      fetch_pend_q <= 1'b0;
      daddr_q      <= '0;
      faddr_q      <= '0;
      wdata_q      <= '0;
      instr_q      <= DATA_W'(BUBBLE_INSTR);
      dout_q       <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (data_req) begin
          // Both read and write high is resolved as a store and flagged.
          op_q         <= cpu.data_write ? OP_WRITE : OP_READ;
          daddr_q      <= cpu.data_addr;
          wdata_q      <= cpu.data_in;
          fetch_pend_q <= cpu.instr_read;
          faddr_q      <= cpu.instr_addr;
          if (cpu.data_read && cpu.data_write) bus_err_q <= 1'b1;
        end else if (cpu.instr_read) begin
          fetch_pend_q <= 1'b1;
          faddr_q      <= cpu.instr_addr;
        end
      end
      if (state_q == S_DATA && access_done && op_q == OP_READ)
        dout_q <= mem.mem_ready ? mem.mem_rdata : '0;
      if (state_q == S_FETCH && access_done)
        instr_q <= mem.mem_ready ? mem.mem_rdata : DATA_W'(BUBBLE_INSTR);
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // Memory-side outputs depend only on state and captured registers.
  assign mem.mem_req   = in_access;
  assign mem.mem_we    = (state_q == S_DATA) && (op_q == OP_WRITE);
  assign mem.mem_addr  = (state_q == S_DATA)  ? daddr_q :
                         (state_q == S_FETCH) ? faddr_q : '0;
  assign mem.mem_wdata = mem.mem_we ? wdata_q : '0;

  assign cpu.stall    = in_access ||
                        ((state_q == S_IDLE) && (data_req || cpu.instr_read));
  assign cpu.instr_out = instr_q;
  assign cpu.data_out  = dout_q;
  assign cpu.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic        rdy_v;
  logic [31:0] rd_v;

  arb_cpu_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();
  arb_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_bus),
    .mem (mem_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bench cycle: drive inputs after the falling edge, settle, return
  // so the caller can sample before the next rising edge.
  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] di,
                       input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    cpu_bus.instr_read = ir;
    cpu_bus.instr_addr = ia;
    cpu_bus.data_read  = dr;
    cpu_bus.data_write = dw;
    cpu_bus.data_addr  = da;
    cpu_bus.data_in    = di;
    mem_bus.mem_ready  = rdy;
    mem_bus.mem_rdata  = rd;
    #1;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] rd);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, rd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cpu_bus.instr_read = 1'b0; cpu_bus.instr_addr = 32'h0;
    cpu_bus.data_read  = 1'b0; cpu_bus.data_write = 1'b0;
    cpu_bus.data_addr  = 32'h0; cpu_bus.data_in = 32'h0;
    mem_bus.mem_ready  = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle(1'b0, 32'h0);
    chk("rst_stall",   32'(cpu_bus.stall),   32'd0);
    chk("rst_req",     32'(mem_bus.mem_req), 32'd0);
    chk("rst_we",      32'(mem_bus.mem_we),  32'd0);
    chk("rst_berr",    32'(cpu_bus.bus_err), 32'd0);
    chk("rst_addr",    mem_bus.mem_addr,     32'h0);
    chk("rst_wdata",   mem_bus.mem_wdata,    32'h0);
    chk("rst_instr",   cpu_bus.instr_out,    32'h0);
    chk("rst_dout",    cpu_bus.data_out,     32'h0);
    $display("TXN reset");

    // Fetch only, zero wait
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("f_stall1", 32'(cpu_bus.stall),   32'd1);
    chk("f_req1",   32'(mem_bus.mem_req), 32'd0);
    idle(1'b1, 32'h00500093);
    chk("f_stall2", 32'(cpu_bus.stall),   32'd1);
    chk("f_req2",   32'(mem_bus.mem_req), 32'd1);
    chk("f_we2",    32'(mem_bus.mem_we),  32'd0);
    chk("f_addr2",  mem_bus.mem_addr,     32'h40);
    idle(1'b0, 32'h0);
    chk("f_stall3", 32'(cpu_bus.stall),   32'd0);
    chk("f_instr3", cpu_bus.instr_out,    32'h00500093);
    chk("f_req3",   32'(mem_bus.mem_req), 32'd0);
    idle(1'b0, 32'h0);
    chk("f_idle_stall", 32'(cpu_bus.stall), 32'd0);
    $display("TXN fetch addr=00000040 instr=%h", cpu_bus.instr_out);

    // Load 0x100 + fetch 0x44, two wait cycles on each access
    for (int c = 1; c <= 8; c++) begin
      rdy_v = (c == 4) || (c == 7);
      rd_v  = (c == 4) ? 32'h11223344 : (c == 7) ? 32'hAABBCCDD : 32'hFFFFFFFF;
      if (c == 1) drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, rdy_v, rd_v);
      else        idle(rdy_v, rd_v);
      chk($sformatf("ld_stall_c%0d", c), 32'(cpu_bus.stall), (c == 8) ? 32'd0 : 32'd1);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("ld_req_c%0d", c),  32'(mem_bus.mem_req), 32'd1);
        chk($sformatf("ld_we_c%0d", c),   32'(mem_bus.mem_we),  32'd0);
        chk($sformatf("ld_addr_c%0d", c), mem_bus.mem_addr,     32'h100);
      end
      if (c >= 5 && c <= 7) begin
        chk($sformatf("ldf_addr_c%0d", c), mem_bus.mem_addr,     32'h44);
        chk($sformatf("ldf_we_c%0d", c),   32'(mem_bus.mem_we),  32'd0);
      end
      if (c == 8) begin
        chk("ld_dout",  cpu_bus.data_out,  32'h11223344);
        chk("ld_instr", cpu_bus.instr_out, 32'hAABBCCDD);
      end
    end
    $display("TXN load addr=00000100 data=%h + fetch addr=00000044 instr=%h",
             cpu_bus.data_out, cpu_bus.instr_out);

    // Store 0xDEADBEEF to 0x200 + fetch 0x48, zero wait
    drive(1'b1, 32'h48, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("st_stall1", 32'(cpu_bus.stall), 32'd1);
    idle(1'b1, 32'h55555555);
    chk("st_req",   32'(mem_bus.mem_req), 32'd1);
    chk("st_we",    32'(mem_bus.mem_we),  32'd1);
    chk("st_addr",  mem_bus.mem_addr,     32'h200);
    chk("st_wdata", mem_bus.mem_wdata,    32'hDEADBEEF);
    idle(1'b1, 32'h00A00113);
    chk("stf_we",    32'(mem_bus.mem_we), 32'd0);
    chk("stf_addr",  mem_bus.mem_addr,    32'h48);
    chk("stf_wdata", mem_bus.mem_wdata,   32'h0);
    idle(1'b0, 32'h0);
    chk("st_stall4", 32'(cpu_bus.stall),   32'd0);
    chk("st_dout",   cpu_bus.data_out,     32'h11223344);
    chk("st_instr",  cpu_bus.instr_out,    32'h00A00113);
    chk("st_berr",   32'(cpu_bus.bus_err), 32'd0);
    $display("TXN store addr=00000200 wdata=deadbeef + fetch instr=%h", cpu_bus.instr_out);

    // Reset during DATA with a pending fetch
    drive(1'b1, 32'h4C, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    idle(1'b1, 32'h77777777);
    chk("rm_req_before", 32'(mem_bus.mem_req), 32'd1);
    rst = 1'b1;
    idle(1'b0, 32'h0);
    rst = 1'b0;
    chk("rm_req",   32'(mem_bus.mem_req), 32'd0);
    chk("rm_stall", 32'(cpu_bus.stall),   32'd0);
    chk("rm_addr",  mem_bus.mem_addr,     32'h0);
    chk("rm_dout",  cpu_bus.data_out,     32'h0);
    chk("rm_instr", cpu_bus.instr_out,    32'h0);
    chk("rm_berr",  32'(cpu_bus.bus_err), 32'd0);
    idle(1'b0, 32'h0);
    chk("rm_req2",  32'(mem_bus.mem_req), 32'd0);
    $display("TXN reset mid-access");

    // Refill instr_out so the timeout's bubble is visible
    drive(1'b1, 32'h54, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idle(1'b1, 32'h12345678);
    idle(1'b0, 32'h0);
    chk("rf_instr", cpu_bus.instr_out, 32'h12345678);
    $display("TXN fetch addr=00000054 instr=%h", cpu_bus.instr_out);

    // Fetch with no answer: 15 wait cycles then abort
    for (int c = 1; c <= 17; c++) begin
      if (c == 1) drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      else        idle(1'b0, 32'h0);
      if (c == 2 || c == 16) begin
        chk($sformatf("to_req_c%0d", c),   32'(mem_bus.mem_req), 32'd1);
        chk($sformatf("to_stall_c%0d", c), 32'(cpu_bus.stall),   32'd1);
        chk($sformatf("to_berr_c%0d", c),  32'(cpu_bus.bus_err), 32'd0);
      end
      if (c == 17) begin
        chk("to_stall_done", 32'(cpu_bus.stall),   32'd0);
        chk("to_req_done",   32'(mem_bus.mem_req), 32'd0);
        chk("to_instr",      cpu_bus.instr_out,    32'h0);
        chk("to_berr",       32'(cpu_bus.bus_err), 32'd1);
      end
    end
    // Late ready outside an access is ignored; bus_err stays set
    idle(1'b1, 32'h99999999);
    chk("to_ign_req",   32'(mem_bus.mem_req), 32'd0);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    chk("to_ign_instr", cpu_bus.instr_out,    32'h0);
    chk("to_berr_hold", 32'(cpu_bus.bus_err), 32'd1);
    $display("TXN fetch timeout addr=00000050 instr=%h bus_err=%0d",
             cpu_bus.instr_out, cpu_bus.bus_err);

    // Read and write both high: store issued and bus_err set
    rst = 1'b1;
    idle(1'b0, 32'h0);
    rst = 1'b0;
    chk("rw_berr_rst", 32'(cpu_bus.bus_err), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h208, 32'hCAFEF00D, 1'b0, 32'h0);
    chk("rw_stall1", 32'(cpu_bus.stall), 32'd1);
    idle(1'b1, 32'h31313131);
    chk("rw_we",    32'(mem_bus.mem_we),  32'd1);
    chk("rw_addr",  mem_bus.mem_addr,     32'h208);
    chk("rw_wdata", mem_bus.mem_wdata,    32'hCAFEF00D);
    chk("rw_berr",  32'(cpu_bus.bus_err), 32'd1);
    idle(1'b0, 32'h0);
    chk("rw_stall3", 32'(cpu_bus.stall), 32'd0);
    chk("rw_dout",   cpu_bus.data_out,   32'h0);
    $display("TXN read+write addr=00000208 bus_err=%0d", cpu_bus.bus_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and stall sequencer for the five-stage pipeline CPU. Each CPU step can present an instruction fetch (IF stage) and a data access (MEM stage) in the same cycle. This block serialises both onto one shared memory port with a ready handshake, returns the results, and holds the whole pipeline (PC and all stage registers) via `stall` until both accesses complete. A wait-cycle watchdog flags memories that never answer.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `WAIT_MAX`, default 15: maximum cycles `mem_req` is held without `mem_ready` before abort.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_read`  in  1  CPU fetch request.
- `instr_addr`  in  ADDR_W  fetch address.
- `instr_out`  out  DATA_W  fetched instruction.
- `data_read`  in  1  CPU load request.
- `data_write`  in  1  CPU store request.
- `data_addr`  in  ADDR_W  load/store address.
- `data_in`  in  DATA_W  store data from the CPU.
- `data_out`  out  DATA_W  load result.
- `stall`  out  1  pipeline hold; the CPU advances only in a cycle where this is 0.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`.
- `bus_err`  out  1  sticky error flag, cleared only by `rst`.

## Operation
FSM states: IDLE, DATA, FETCH, DONE.

- **IDLE**
  - If `data_read|data_write`: capture `data_addr`, `data_in`, op and `instr_read`/`instr_addr`; go to DATA.
  - Else if `instr_read`: capture fetch address; go to FETCH.
  - Else stay in IDLE.
- **DATA**
  - `mem_req`=1; `mem_we`=1 for a store; address and write data come from the captured registers.
  - On `mem_ready`: for a load, latch `mem_rdata` into `data_out`.
  - Next state is FETCH if a fetch was captured, else DONE.
- **FETCH**
  - `mem_req`=1, `mem_we`=0, address = captured fetch address.
  - On `mem_ready`: latch `mem_rdata` into `instr_out`; go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle; the CPU samples `instr_out`/`data_out` at this edge.
  - Next state is IDLE.

Rules:
- `stall` = 1 in DATA and FETCH, and in IDLE when any request is present. `stall` = 0 in DONE and in IDLE with no request.
- Data access is always serviced before fetch within one step.
- `data_read` and `data_write` both high: treated as a store, and `bus_err` is set.
- Watchdog: an up-counter runs in DATA/FETCH while `mem_ready`=0 and clears on every state change.
  - When the counter reaches `WAIT_MAX`, the access is aborted: `bus_err` is set, the result register loads 0 (0 is the CPU flush/bubble encoding), and the FSM advances exactly as on `mem_ready`.
- `instr_out`/`data_out` hold their last value until overwritten.
- `mem_ready` outside DATA/FETCH is ignored.

## Timing
- Reset values: state IDLE; `stall`, `mem_req`, `mem_we`, `bus_err` = 0; `mem_addr`, `mem_wdata`, `instr_out`, `data_out` = 0; watchdog = 0.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are decoded from the state and captured registers only; they have no combinational path from the CPU inputs.
- With a zero-wait memory (`mem_ready` high in the first request cycle):
  - fetch-only step = 3 cycles (IDLE, FETCH, DONE), with `stall` high for 2 cycles.
  - load/store + fetch step = 4 cycles.
- Each memory wait cycle adds 1 cycle to the step.
- Reset mid-transaction: at the next edge the FSM returns to IDLE and `mem_req` drops. The memory must tolerate the abandoned request, and no result register is updated.

## Structure
- `mem_arb_pkg` holds:
  - the state enum `arb_state_t`;
  - constants `OP_READ`/`OP_WRITE`;
  - the reset value `BUBBLE_INSTR` = 32'h0.
- One sub-module, `arb_wait_timer`: the watchdog counter, with clear/enable inputs and a `WAIT_MAX` parameter, producing a `timeout` pulse.

## Test plan
- Fetch only, `instr_addr`=0x40, `mem_ready` immediate, `mem_rdata`=0x00500093 -> `mem_addr`=0x40 one cycle after the request; `stall` 1,1,0; `instr_out`=0x00500093 in DONE.
- Load at 0x100 plus fetch at 0x44, 2 wait cycles on each -> DATA phase with `mem_we`=0 to 0x100, then FETCH to 0x44; `data_out`=`mem_rdata` of the first access; `stall` low only in cycle 8.
- Store of 0xDEADBEEF to 0x200 plus fetch -> one cycle with `mem_req`=1, `mem_we`=1, `mem_wdata`=0xDEADBEEF; `data_out` unchanged.
- `mem_ready` never asserted on a fetch -> after 15 wait cycles the FSM advances, `instr_out`=0, `bus_err`=1 and stays 1 until `rst`.
- `rst` asserted during DATA with a pending fetch -> next cycle: state IDLE, `mem_req`=0, all outputs at reset values.
- `data_read`=`data_write`=1 -> store issued, `bus_err`=1.
